// File: rtl/cu_pkg.sv
// Shared types and encodings for the parametrised multicycle control unit.
// Opcodes, FSM states, datapath select encodings and the control bundle.
package cu_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LB    = 6'b100000,
    OP_SB    = 6'b101000
  } opcode_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_BEQ, S_BNE, S_ADDIEX, S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [1:0] ASB_REG  = 2'b00;
  localparam logic [1:0] ASB_ONE  = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;
  localparam logic [1:0] ASB_BOFF = 2'b11;

  localparam logic [1:0] PCS_ALU  = 2'b00;
  localparam logic [1:0] PCS_ALUO = 2'b01;
  localparam logic [1:0] PCS_JMP  = 2'b10;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       regdst;
    logic       iord;
    logic       pcwrite;
    logic       branch;
    logic       branchne;
    logic       alusrca;
    logic       regwrite;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cu_fetch_seq.sv
// Instruction byte sequencer: walks the byte counter during FETCH and
// produces the one-hot instruction-register byte enable.
module cu_fetch_seq
  import cu_pkg::*;
#(
  parameter int FETCH_BYTES = 4,
  localparam int CW = cnt_w(FETCH_BYTES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   rdy,
  output logic [CW-1:0]          cnt,
  output logic                   last,
  output logic [FETCH_BYTES-1:0] irwrite
);

  localparam logic [CW-1:0] LAST = CW'(FETCH_BYTES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          step;

  assign step = en && rdy;
  assign last = (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d   = cnt_q;
    irwrite = '0;
    if (step) begin
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      irwrite = FETCH_BYTES'(1) << cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cu_param.sv
// Multicycle MIPS control unit with a parametrised byte fetch and
// memory-ready stalls; drives the byte-wide datapath enables.
module cu_param
  import cu_pkg::*;
#(
  parameter int FETCH_BYTES   = 4,
  parameter int USE_MEM_READY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   memtoreg,
  output logic                   memwrite,
  output logic                   regdst,
  output logic                   iord,
  output logic                   pcwrite,
  output logic                   branch,
  output logic                   branchne,
  output logic                   alusrcA,
  output logic                   regwrite,
  output logic [1:0]             pcsrc,
  output logic [1:0]             alusrcB,
  output logic [1:0]             aluop,
  output logic [FETCH_BYTES-1:0] irwrite,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [3:0]             state_dbg
);

  localparam int CW = cnt_w(FETCH_BYTES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FETCH_BYTES - 1);

  state_t        state_q, state_d;
  ctrl_t         c, g;
  logic          rdy;
  logic          fetch_en;
  logic          fetch_last;
  logic [CW-1:0] byte_cnt;

  assign rdy      = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign fetch_en = reset && (state_q == S_FETCH);

  cu_fetch_seq #(.FETCH_BYTES(FETCH_BYTES)) u_fetch (
    .clk     (clk),
    .reset   (reset),
    .en      (fetch_en),
    .rdy     (rdy),
    .cnt     (byte_cnt),
    .last    (fetch_last),
    .irwrite (irwrite)
  );

  a_cnt_range: assert property (
    @(posedge clk) disable iff (!reset) byte_cnt <= CNT_MAX);

  always_comb begin
    c       = '0;
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        c.alusrcb = ASB_ONE;
        c.pcwrite = rdy;
        if (rdy && fetch_last) state_d = S_DECODE;
      end
      S_DECODE: begin
        c.alusrca = 1'b1;
        c.alusrcb = ASB_BOFF;
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d      = S_FETCH;
            c.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ASB_IMM;
        state_d   = (op == OP_SB) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        c.iord = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        if (rdy) begin
          c.instr_done = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXEC: begin
        c.alusrca = 1'b1;
        c.aluop   = ALU_FN;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ, S_BNE: begin
        c.alusrca    = 1'b1;
        c.aluop      = ALU_SUB;
        c.pcsrc      = PCS_ALUO;
        c.branch     = (state_q == S_BEQ);
        c.branchne   = (state_q == S_BNE);
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ASB_IMM;
        c.aluop   = ALU_ADD;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        c.pcwrite    = 1'b1;
        c.pcsrc      = PCS_JMP;
        c.instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // reset low must kill every enable at once, even mid-instruction
  assign g = reset ? c : '0;

  assign memtoreg   = g.memtoreg;
  assign memwrite   = g.memwrite;
  assign regdst     = g.regdst;
  assign iord       = g.iord;
  assign pcwrite    = g.pcwrite;
  assign branch     = g.branch;
  assign branchne   = g.branchne;
  assign alusrcA    = g.alusrca;
  assign regwrite   = g.regwrite;
  assign pcsrc      = g.pcsrc;
  assign alusrcB    = g.alusrcb;
  assign aluop      = g.aluop;
  assign instr_done = g.instr_done;
  assign illegal_op = g.illegal_op;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cu_param.sv
// Randomised bench for cu_param: per-instruction expected output traces
// for three configurations (4 bytes, 2 bytes, 1 byte without mem_ready).
module tb_cu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] op;
  logic       mem_ready;
  logic [2:0] rstv;

  logic m2r[3], mw[3], rdst[3], iord[3], pcw[3], br[3], bne[3];
  logic asa[3], rw[3], done[3], ill[3];
  logic [1:0] psrc[3], asb[3], aop[3];
  logic [3:0] sdbg[3];
  logic [3:0] irw0;
  logic [1:0] irw1;
  logic [0:0] irw2;
  logic [28:0] obs[3];

  cu_param #(.FETCH_BYTES(4), .USE_MEM_READY(1)) u0 (
    .clk(clk), .reset(rstv[0]), .op(op), .mem_ready(mem_ready),
    .memtoreg(m2r[0]), .memwrite(mw[0]), .regdst(rdst[0]),
    .iord(iord[0]), .pcwrite(pcw[0]), .branch(br[0]),
    .branchne(bne[0]), .alusrcA(asa[0]), .regwrite(rw[0]),
    .pcsrc(psrc[0]), .alusrcB(asb[0]), .aluop(aop[0]),
    .irwrite(irw0), .instr_done(done[0]), .illegal_op(ill[0]),
    .state_dbg(sdbg[0]));

  cu_param #(.FETCH_BYTES(2), .USE_MEM_READY(1)) u1 (
    .clk(clk), .reset(rstv[1]), .op(op), .mem_ready(mem_ready),
    .memtoreg(m2r[1]), .memwrite(mw[1]), .regdst(rdst[1]),
    .iord(iord[1]), .pcwrite(pcw[1]), .branch(br[1]),
    .branchne(bne[1]), .alusrcA(asa[1]), .regwrite(rw[1]),
    .pcsrc(psrc[1]), .alusrcB(asb[1]), .aluop(aop[1]),
    .irwrite(irw1), .instr_done(done[1]), .illegal_op(ill[1]),
    .state_dbg(sdbg[1]));

  cu_param #(.FETCH_BYTES(1), .USE_MEM_READY(0)) u2 (
    .clk(clk), .reset(rstv[2]), .op(op), .mem_ready(mem_ready),
    .memtoreg(m2r[2]), .memwrite(mw[2]), .regdst(rdst[2]),
    .iord(iord[2]), .pcwrite(pcw[2]), .branch(br[2]),
    .branchne(bne[2]), .alusrcA(asa[2]), .regwrite(rw[2]),
    .pcsrc(psrc[2]), .alusrcB(asb[2]), .aluop(aop[2]),
    .irwrite(irw2), .instr_done(done[2]), .illegal_op(ill[2]),
    .state_dbg(sdbg[2]));

  assign obs[0] = {sdbg[0], 4'b0, irw0, pcw[0], asa[0], asb[0],
                   aop[0], psrc[0], iord[0], mw[0], m2r[0], rdst[0],
                   rw[0], br[0], bne[0], done[0], ill[0]};
  assign obs[1] = {sdbg[1], 6'b0, irw1, pcw[1], asa[1], asb[1],
                   aop[1], psrc[1], iord[1], mw[1], m2r[1], rdst[1],
                   rw[1], br[1], bne[1], done[1], ill[1]};
  assign obs[2] = {sdbg[2], 7'b0, irw2, pcw[2], asa[2], asb[2],
                   aop[2], psrc[2], iord[2], mw[2], m2r[2], rdst[2],
                   rw[2], br[2], bne[2], done[2], ill[2]};

  typedef struct {
    bit          d;
    logic [28:0] e;
    string       n;
  } item_t;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cfg;
  int    fb[3]   = '{4, 2, 1};
  bit    ur[3]   = '{1'b1, 1'b1, 1'b0};
  logic [5:0] opv[7] = '{6'b100000, 6'b101000, 6'b000000,
                         6'b000100, 6'b000101, 6'b001000, 6'b000010};

  task automatic chk(input string tag, input logic [28:0] got,
                     input logic [28:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // field order: state irw pcw srcA srcB aluop pcsrc iord mw m2r rd rw br bne done ill
  function automatic logic [28:0] mk(
    int st, int irw, int pw, int sa, int sb, int ao, int ps, int io,
    int w, int m2, int rd, int r, int b, int bn, int dn, int il);
    return {st[3:0], irw[7:0], pw[0], sa[0], sb[1:0], ao[1:0],
            ps[1:0], io[0], w[0], m2[0], rd[0], r[0], b[0], bn[0],
            dn[0], il[0]};
  endfunction

  function automatic bit rnd();
    return 1'($urandom);
  endfunction

  function automatic bit rd1();
    return ur[cfg] ? 1'b1 : rnd();
  endfunction

  function automatic int stalls();
    return ur[cfg] ? int'($urandom_range(0, 2)) : 0;
  endfunction

  task automatic push(input bit d, input logic [28:0] e, input string n);
    q.push_back('{d, e, n});
  endtask

  task automatic build(input int kind);
    int k;
    q.delete();
    for (int b = 0; b < fb[cfg]; b++) begin
      k = stalls();
      repeat (k)
        push(1'b0, mk(0,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0), "fetch_wait");
      push(rd1(), mk(0,1<<b,1,0,1,0,0,0,0,0,0,0,0,0,0,0), "fetch");
    end
    push(rnd(), mk(1,0,0,1,3,0,0,0,0,0,0,0,0,0,0,kind==7), "decode");
    case (kind)
      0, 1: begin
        push(rnd(), mk(2,0,0,1,2,0,0,0,0,0,0,0,0,0,0,0), "memadr");
        k = stalls();
        if (kind == 0) begin
          repeat (k)
            push(1'b0, mk(3,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0), "memrd_wait");
          push(rd1(), mk(3,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0), "memrd");
          push(rnd(), mk(4,0,0,0,0,0,0,0,0,1,0,1,0,0,1,0), "memwb");
        end else begin
          repeat (k)
            push(1'b0, mk(5,0,0,0,0,0,0,1,1,0,0,0,0,0,0,0), "memwr_wait");
          push(rd1(), mk(5,0,0,0,0,0,0,1,1,0,0,0,0,0,1,0), "memwr");
        end
      end
      2: begin
        push(rnd(), mk(6,0,0,1,0,2,0,0,0,0,0,0,0,0,0,0), "exec");
        push(rnd(), mk(7,0,0,0,0,0,0,0,0,0,1,1,0,0,1,0), "aluwb");
      end
      3: push(rnd(), mk(8,0,0,1,0,1,1,0,0,0,0,0,1,0,1,0), "beq");
      4: push(rnd(), mk(9,0,0,1,0,1,1,0,0,0,0,0,0,1,1,0), "bne");
      5: begin
        push(rnd(), mk(10,0,0,1,2,0,0,0,0,0,0,0,0,0,0,0), "addiex");
        push(rnd(), mk(11,0,0,0,0,0,0,0,0,0,0,1,0,0,1,0), "addiwb");
      end
      6: push(rnd(), mk(12,0,1,0,0,0,2,0,0,0,0,0,0,0,1,0), "jump");
      default: ;
    endcase
  endtask

  function automatic logic [5:0] illegal_opcode();
    logic [5:0] o;
    bit hit;
    do begin
      o = 6'($urandom);
      hit = 1'b0;
      foreach (opv[j]) if (opv[j] == o) hit = 1'b1;
    end while (hit);
    return o;
  endfunction

  initial begin
    int kind, abort_at;
    bit aborted;
    rstv      = 3'b000;
    op        = 6'd0;
    mem_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      cfg = c;
      for (int r = 0; r < 3; r++) begin
        mem_ready = rnd();
        op        = 6'($urandom);
        #1 chk($sformatf("c%0d_reset%0d", c, r), obs[c], '0);
        @(negedge clk);
      end
      rstv[c] = 1'b1;
      for (int n = 0; n < 80; n++) begin
        kind = (n < 8) ? n : int'($urandom_range(0, 7));
        op   = (kind == 7) ? illegal_opcode() : opv[kind];
        build(kind);
        abort_at = ($urandom_range(0, 9) == 0) ?
                   int'($urandom_range(0, q.size() - 1)) : -1;
        if (c == 1 && n == 0) abort_at = q.size() - 2;
        aborted = 1'b0;
        for (int i = 0; i < q.size() && !aborted; i++) begin
          mem_ready = q[i].d;
          #1 chk($sformatf("c%0d_n%0d_%s", c, n, q[i].n), obs[c], q[i].e);
          if (i == abort_at) begin
            aborted = 1'b1;
            rstv[c] = 1'b0;
            #1 chk($sformatf("c%0d_n%0d_rst_now", c, n), obs[c], '0);
            @(negedge clk);
            mem_ready = rnd();
            #1 chk($sformatf("c%0d_n%0d_rst_hold", c, n), obs[c], '0);
            @(negedge clk);
            rstv[c] = 1'b1;
          end else begin
            @(negedge clk);
          end
        end
      end
      rstv[c] = 1'b0;
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_param.md
Name: cu_param

Overview:
- Parametrised multicycle control unit for the byte-wide MIPS datapath. Next generation of the fixed 4-byte-fetch controller.
- Fetches an instruction of FETCH_BYTES bytes through a byte counter rather than fixed states.
- Stalls on a memory-ready handshake.
- Adds ADDI and BNE, plus illegal-opcode and instruction-done pulses.
- Sits between the instruction register opcode field and the datapath enables. ALU function decode remains in the separate ALU decoder.

Parameters:
- FETCH_BYTES, 4, instruction bytes fetched per instruction; legal range 1..8; sets irwrite width.
- USE_MEM_READY, 1, 1 = fetch/load/store wait for mem_ready; 0 = mem_ready ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from the instruction register, valid from the DECODE state onward.
- mem_ready  in  1  memory has completed the current access this cycle.
- memtoreg  out  1  register write data comes from the memory data register.
- memwrite  out  1  memory write strobe.
- regdst  out  1  destination register is rd (1) or rt (0).
- iord  out  1  memory address comes from the ALU output (1) or the PC (0).
- pcwrite  out  1  unconditional PC write.
- branch  out  1  PC write if the zero flag is set (BEQ).
- branchne  out  1  PC write if the zero flag is clear (BNE).
- alusrcA  out  1  ALU A input is register A (1) or the PC (0).
- regwrite  out  1  register file write.
- pcsrc  out  2  00 ALU result, 01 ALU output register, 10 jump target.
- alusrcB  out  2  00 register B, 01 constant 1, 10 immediate, 11 branch offset.
- aluop  out  2  00 add, 01 subtract, 10 use the funct field.
- irwrite  out  FETCH_BYTES  one-hot instruction-register byte enable.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unknown opcode.
- state_dbg  out  4  current state encoding, for debug only.

Behaviour:
- Reset: asynchronous and active-low. While reset=0: state=FETCH, byte count=0, and every output is 0 (all enables gated by reset). state_dbg=FETCH.
- Release: the first fetch is eligible on the first rising edge with reset=1.
- Opcodes: LB 100000, SB 101000, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
- Outputs are 0 unless listed for a state. rdy = mem_ready, or 1 when USE_MEM_READY=0.
- FETCH:
  - Outputs: alusrcB=01 always; pcwrite=rdy; irwrite=rdy ? (1<<cnt) : 0.
  - If rdy and cnt=FETCH_BYTES-1: cnt<=0 and go to DECODE.
  - Else if rdy: cnt<=cnt+1 and stay in FETCH.
  - Else: hold state and cnt.
- DECODE:
  - Outputs: alusrcA=1, alusrcB=11.
  - Transitions: LB/SB->MEMADR, RTYPE->EXEC, BEQ->BEQ, BNE->BNE, ADDI->ADDIEX, J->JUMP.
  - Any other opcode: go to FETCH and pulse illegal_op=1.
- MEMADR: alusrcA=1, alusrcB=10. LB->MEMRD, SB->MEMWR.
- MEMRD: iord=1. Go to MEMWB when rdy, else stay.
- MEMWB: regwrite=1, memtoreg=1, instr_done=1. Go to FETCH.
- MEMWR:
  - Outputs: iord=1, memwrite=1 held for the whole wait.
  - When rdy: instr_done=1, go to FETCH. Else stay.
- EXEC: alusrcA=1, aluop=10. Go to ALUWB.
- ALUWB: regdst=1, regwrite=1, instr_done=1. Go to FETCH.
- BEQ: alusrcA=1, aluop=01, branch=1, pcsrc=01, instr_done=1. Go to FETCH.
- BNE: as BEQ but branchne=1 and branch=0. Go to FETCH.
- ADDIEX: alusrcA=1, alusrcB=10, aluop=00. Go to ADDIWB.
- ADDIWB: regwrite=1, instr_done=1. Go to FETCH.
- JUMP: pcwrite=1, pcsrc=10, instr_done=1. Go to FETCH.
- Unused state encodings: all outputs 0, next state FETCH.
- Latency with rdy always 1 (F = FETCH_BYTES):
  - LB: F+4 cycles. SB: F+3. RTYPE: F+3. ADDI: F+3. BEQ/BNE/J: F+2. Illegal opcode: F+1.
- Byte counter: width max(1,$clog2(FETCH_BYTES)). It never exceeds FETCH_BYTES-1 and wraps only through the DECODE transition.
- op is sampled combinationally in DECODE and MEMADR. The instruction register is stable there because irwrite=0.
- An async reset asserted mid-instruction abandons it immediately: no pending write completes after reset falls.

Decomposition:
- cu_pkg holds:
  - opcode_t enum (6-bit) with the values above.
  - state_t enum (4-bit): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BEQ, BNE, ADDIEX, ADDIWB, JUMP.
  - localparams for the alusrcB, pcsrc and aluop encodings.
- One sub-module, cu_fetch_seq, parameterised by FETCH_BYTES:
  - Inputs: clk, reset, en, rdy.
  - Outputs: byte count, last flag, one-hot irwrite.
- cu_param holds the state register and the next-state and output logic.

Test Plan:
- Reset held low for 3 cycles, then released; rdy=1, FETCH_BYTES=4 -> all outputs 0 during reset; then irwrite 0001,0010,0100,1000 on consecutive cycles with pcwrite=1 each; DECODE on cycle 5.
- LB (op=100000), rdy=1 -> state sequence FETCHx4, DECODE, MEMADR, MEMRD, MEMWB; regwrite=memtoreg=1 and instr_done=1 in cycle 8 only.
- SB with mem_ready low for 3 cycles in MEMWR -> memwrite=iord=1 for 4 cycles; instr_done only on the rdy cycle; then FETCH.
- Fetch stall: mem_ready=0 during byte 2 for 2 cycles -> irwrite=0 and pcwrite=0 while stalled; byte count holds at 1; resumes with irwrite=0010.
- BNE (000101), ADDI (001000), J (000010) -> BNE: branchne=1, pcsrc=01, aluop=01. ADDI: ADDIEX alusrcB=10, then ADDIWB regwrite=1, regdst=0. J: pcwrite=1, pcsrc=10.
- op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH. Repeat with FETCH_BYTES=2 -> irwrite 01,10, and reset mid-MEMRD forces all outputs to 0 at once.
